// File: rtl/ir_nec_rx.sv
// ---------------------------------------------------------------------------
// ir_nec_rx -- NEC infrared remote-control frame receiver
//
// Decodes the demodulated output of an IR receiver module (active-low, a
// "mark" is the carrier-present interval) into NEC frames.  Every mark and
// space is timed in 1 us ticks and classified when the edge that ends it
// arrives.  Bits are collected LSB-first; on a good stop mark the payload is
// published on o_data with a one-clk o_valid pulse.
//
// Build option:
//   IR_NEC_RX_REPEAT_EN -- when defined, the NEC repeat code
//                          (9 ms mark, 2.25 ms space, 560 us mark) is
//                          recognised and reported on o_repeat; when
//                          undefined, a repeat-length lead space is an error
//                          and o_repeat is tied low.
//
// Parameters:
//   CLK_HZ      clk frequency in Hz (tick divider = CLK_HZ/1e6)
//   NBITS       payload bits per frame (8..32)
//   TOL_PCT     symmetric timing tolerance in percent (5..40)
//   CHK_EN      with NBITS==32, require bits[31:24] == ~bits[23:16]
//   TIMEOUT_US  longest legal mark or space; longer aborts the frame
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   i_ir_rxb   raw IR receiver output, active-low (mark = 0), asynchronous
//   o_data     payload of the last accepted frame
//   o_valid    one-clk pulse when o_data updates
//   o_repeat   one-clk pulse on an accepted repeat code
//   o_err      one-clk pulse on a rejected frame / repeat / timeout
//   o_busy     high while a frame is being received (state not IDLE)
// ---------------------------------------------------------------------------
module ir_nec_rx #(
    parameter int CLK_HZ     = 50000000,
    parameter int NBITS      = 32,
    parameter int TOL_PCT    = 20,
    parameter int CHK_EN     = 1,
    parameter int TIMEOUT_US = 12000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ir_rxb,
    output logic [NBITS-1:0] o_data,
    output logic             o_valid,
    output logic             o_repeat,
    output logic             o_err,
    output logic             o_busy
);

    // -----------------------------------------------------------------------
    // Elaboration-time constants
    // -----------------------------------------------------------------------
    localparam int DIV_RAW = CLK_HZ / 1000000;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BC_W    = $clog2(NBITS + 1);

    localparam int LO_PCT = 100 - TOL_PCT;
    localparam int HI_PCT = 100 + TOL_PCT;

    // Acceptance windows in ticks, both bounds inclusive.
    localparam logic [15:0] LM_LO = 16'(9000 * LO_PCT / 100);  // lead mark
    localparam logic [15:0] LM_HI = 16'(9000 * HI_PCT / 100);
    localparam logic [15:0] LS_LO = 16'(4500 * LO_PCT / 100);  // lead space
    localparam logic [15:0] LS_HI = 16'(4500 * HI_PCT / 100);
    localparam logic [15:0] BM_LO = 16'(560  * LO_PCT / 100);  // bit / stop mark
    localparam logic [15:0] BM_HI = 16'(560  * HI_PCT / 100);
    localparam logic [15:0] ZS_LO = 16'(560  * LO_PCT / 100);  // zero space
    localparam logic [15:0] ZS_HI = 16'(560  * HI_PCT / 100);
    localparam logic [15:0] OS_LO = 16'(1690 * LO_PCT / 100);  // one space
    localparam logic [15:0] OS_HI = 16'(1690 * HI_PCT / 100);
`ifdef IR_NEC_RX_REPEAT_EN
    localparam logic [15:0] RS_LO = 16'(2250 * LO_PCT / 100);  // repeat space
    localparam logic [15:0] RS_HI = 16'(2250 * HI_PCT / 100);
`endif

    localparam logic [15:0] TO_TICKS = 16'(TIMEOUT_US);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK
    } state_e;

    function automatic logic in_win(input logic [15:0] w,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]       sync_q,      sync_d;
    logic             mark_prev_q, mark_prev_d;
    logic [DIV_W-1:0] div_q,       div_d;
    logic [15:0]      width_q,     width_d;
    state_e           state_q,     state_d;
    logic [BC_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [NBITS-1:0] shift_q,     shift_d;
    logic [NBITS-1:0] data_q,      data_d;
    logic             valid_q,     valid_d;
    logic             err_q,       err_d;
`ifdef IR_NEC_RX_REPEAT_EN
    logic             repeat_q,    repeat_d;
    logic             seen_q,      seen_d;    // a valid frame arrived since reset
    logic             rpt_q,       rpt_d;     // current stop mark ends a repeat code
`endif

    logic mark;
    logic edge_det;
    logic rise;
    logic tick;
    logic timeout;
    logic chk_ok;
    logic is_zero;
    logic is_one;
    logic fail;

    // -----------------------------------------------------------------------
    // Input conditioning and timebase
    // -----------------------------------------------------------------------
    // i_ir_rxb idles high, so the synchroniser resets to 1 (no mark).
    assign mark     = ~sync_q[1];
    assign edge_det = mark ^ mark_prev_q;
    assign rise     = edge_det & mark;
    assign tick     = (div_q == DIV_W'(DIV - 1));
    assign timeout  = (state_q != S_IDLE) && (width_q > TO_TICKS);

    assign is_zero  = in_win(width_q, ZS_LO, ZS_HI);
    assign is_one   = in_win(width_q, OS_LO, OS_HI);

    // The inverted-address/command check only exists for full 32-bit frames.
    if (NBITS == 32 && CHK_EN != 0) begin : g_chk
        assign chk_ok = (shift_q[31:24] == ~shift_q[23:16]);
    end else begin : g_nochk
        assign chk_ok = 1'b1;
    end

    always_comb begin
        sync_d      = {sync_q[0], i_ir_rxb};
        mark_prev_d = mark;
        div_d       = tick ? '0 : div_q + DIV_W'(1);

        // Width of the interval in progress; the value seen on an edge is the
        // width of the interval that edge terminates.
        if (edge_det) begin
            width_d = '0;
        end else if (tick && (width_q != 16'hFFFF)) begin
            width_d = width_q + 16'd1;
        end else begin
            width_d = width_q;
        end
    end

    // -----------------------------------------------------------------------
    // Frame FSM: next state and output pulses
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        fail      = 1'b0;
`ifdef IR_NEC_RX_REPEAT_EN
        repeat_d  = 1'b0;
        seen_d    = seen_q;
        rpt_d     = rpt_q;
`endif

        case (state_q)
            // Only a rising mark edge seen while already idle starts a frame,
            // so a mark that coincides with an error return is ignored.
            S_IDLE: begin
                if (rise) begin
                    state_d = S_LEAD_MARK;
                end
            end

            S_LEAD_MARK: begin
                if (edge_det) begin
                    if (in_win(width_q, LM_LO, LM_HI)) begin
                        state_d = S_LEAD_SPACE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end

            S_LEAD_SPACE: begin
                if (edge_det) begin
                    if (in_win(width_q, LS_LO, LS_HI)) begin
                        state_d   = S_BIT_MARK;
                        bit_cnt_d = '0;
`ifdef IR_NEC_RX_REPEAT_EN
                        rpt_d     = 1'b0;
                    end else if (in_win(width_q, RS_LO, RS_HI)) begin
                        state_d   = S_STOP_MARK;
                        rpt_d     = 1'b1;
`endif
                    end else begin
                        fail = 1'b1;
                    end
                end
            end

            S_BIT_MARK: begin
                if (edge_det) begin
                    if (in_win(width_q, BM_LO, BM_HI)) begin
                        state_d = S_BIT_SPACE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end

            // Bits shift in from the top so the first one ends up in bit 0.
            S_BIT_SPACE: begin
                if (edge_det) begin
                    if (is_zero || is_one) begin
                        shift_d   = {~is_zero, shift_q[NBITS-1:1]};
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        if (bit_cnt_q == BC_W'(NBITS - 1)) begin
                            state_d = S_STOP_MARK;
                        end else begin
                            state_d = S_BIT_MARK;
                        end
                    end else begin
                        fail = 1'b1;
                    end
                end
            end

            S_STOP_MARK: begin
                if (edge_det) begin
                    if (in_win(width_q, BM_LO, BM_HI)) begin
                        state_d = S_IDLE;
`ifdef IR_NEC_RX_REPEAT_EN
                        if (rpt_q) begin
                            // A repeat only means something once a frame has
                            // been accepted to repeat.
                            repeat_d = seen_q;
                            err_d    = ~seen_q;
                        end else
`endif
                        if (chk_ok) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
`ifdef IR_NEC_RX_REPEAT_EN
                            seen_d  = 1'b1;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        fail = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any error, including an over-long interval still in progress,
        // overrides whatever the case statement decided.
        if (fail || timeout) begin
            state_d = S_IDLE;
            data_d  = data_q;
            valid_d = 1'b0;
            err_d   = 1'b1;
`ifdef IR_NEC_RX_REPEAT_EN
            repeat_d = 1'b0;
            seen_d   = seen_q;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            mark_prev_q <= 1'b0;
            div_q       <= '0;
            width_q     <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef IR_NEC_RX_REPEAT_EN
            repeat_q    <= 1'b0;
            seen_q      <= 1'b0;
            rpt_q       <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            mark_prev_q <= mark_prev_d;
            div_q       <= div_d;
            width_q     <= width_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
`ifdef IR_NEC_RX_REPEAT_EN
            repeat_q    <= repeat_d;
            seen_q      <= seen_d;
            rpt_q       <= rpt_d;
`endif
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_busy  = (state_q != S_IDLE);
`ifdef IR_NEC_RX_REPEAT_EN
    assign o_repeat = repeat_q;
`else
    assign o_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_ir_nec_rx.sv
// ---------------------------------------------------------------------------
// tb_ir_nec_rx -- scoreboard bench for ir_nec_rx
//
// The stimulus side builds NEC waveforms with randomly jittered timings and,
// just before driving the edge that should trigger a response, pushes the
// expected event (kind, o_data, cycle window) into a queue.  A monitor pops
// and compares whenever o_valid / o_repeat / o_err pulses.  The reference
// model tracks only the last accepted payload and whether one was seen.
// ---------------------------------------------------------------------------
module tb_ir_nec_rx;

    localparam int CLK_HZ = 1000000;
    localparam int CPU    = CLK_HZ / 1000000;   // clocks per microsecond
    localparam int NBITS  = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_ir_rxb = 1'b1;
    logic [NBITS-1:0] o_data;
    logic             o_valid;
    logic             o_repeat;
    logic             o_err;
    logic             o_busy;

    ir_nec_rx #(
        .CLK_HZ     (CLK_HZ),
        .NBITS      (NBITS),
        .TOL_PCT    (20),
        .CHK_EN     (1),
        .TIMEOUT_US (12000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_ir_rxb (i_ir_rxb),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_repeat (o_repeat),
        .o_err    (o_err),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_VALID = 0, EV_REPEAT = 1, EV_ERR = 2} ev_e;
    typedef struct {
        ev_e         kind;
        logic [31:0] data;
        longint      lo;
        longint      hi;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_data = '0;   // model: last accepted payload
    bit          m_seen = 1'b0; // model: a valid frame since reset

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input longint v, input longint lo, input longint hi);
        n_vec++;
        if (v < lo || v > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, v, lo, hi);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic bit chk_ok(input logic [31:0] p);
        return p[31:24] == ~p[23:16];
    endfunction

    function automatic logic [31:0] mk_valid(input logic [31:0] r);
        return {~r[23:16], r[23:0]};
    endfunction

    // Nominal width jittered by -10%..+10%, well inside the +-20% windows.
    function automatic int jit(input int nom);
        return nom * (90 + int'($urandom_range(20))) / 100;
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic drive(input bit m, input int us);
        i_ir_rxb = ~m;
        repeat (us * CPU) @(negedge clk);
    endtask

    task automatic push(input ev_e k, input logic [31:0] d, input longint lo, input longint hi);
        exp_t e;
        e.kind = k;
        e.data = d;
        e.lo   = lo;
        e.hi   = hi;
        sb_q.push_back(e);
    endtask

    // Expect a response a few clocks after the edge about to be driven.
    task automatic push_now(input ev_e k, input logic [31:0] d);
        push(k, d, cyc, cyc + 8);
    endtask

    task automatic send_lead();
        drive(1'b1, jit(9000));
        drive(1'b0, jit(4500));
    endtask

    task automatic send_bits(input logic [31:0] p, input int from, input int to);
        for (int i = from; i < to; i++) begin
            drive(1'b1, jit(560));
            drive(1'b0, p[i] ? jit(1690) : jit(560));
        end
    endtask

    task automatic send_frame(input logic [31:0] p);
        send_lead();
        send_bits(p, 0, 32);
        drive(1'b1, jit(560));
        if (chk_ok(p)) begin
            push_now(EV_VALID, p);
            m_data = p;
            m_seen = 1'b1;
        end else begin
            push_now(EV_ERR, m_data);
        end
        drive(1'b0, 2000);
    endtask

    task automatic send_repeat();
        drive(1'b1, jit(9000));
        drive(1'b0, jit(2250));
`ifdef IR_NEC_RX_REPEAT_EN
        drive(1'b1, jit(560));
        if (m_seen) push_now(EV_REPEAT, m_data);
        else        push_now(EV_ERR, m_data);
`else
        push_now(EV_ERR, m_data);
        drive(1'b1, jit(560));
`endif
        drive(1'b0, 2000);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() > 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(sb_q.size()), 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        int   k;
        if (rst_n && (o_valid || o_repeat || o_err)) begin
            k = o_valid ? 0 : (o_repeat ? 1 : 2);
            check("pulse_onehot", 64'($countones({o_valid, o_repeat, o_err})), 1);
            check("event_expected", 64'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("event_kind", 64'(k), 64'(e.kind));
                check("event_o_data", 64'(o_data), 64'(e.data));
                check_range("event_cycle", cyc, e.lo, e.hi);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (900000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 900000 cycles");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [31:0] p;
        longint      t0;
        int          k;

        repeat (5) @(negedge clk);
        check("rst_o_data",   64'(o_data), 0);
        check("rst_o_valid",  64'(o_valid), 0);
        check("rst_o_repeat", 64'(o_repeat), 0);
        check("rst_o_err",    64'(o_err), 0);
        check("rst_o_busy",   64'(o_busy), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Repeat code before any frame: rejected in either build.
        send_repeat();
        wait_drain();

        // Reference frame.
        send_frame(32'hE51AFF00);
        wait_drain();
        check("o_data_ref_frame", 64'(o_data), 64'hE51AFF00);

        // Same frame with bit 24 flipped: check byte mismatch.
        p = 32'hE51AFF00 ^ 32'h0100_0000;
        send_frame(p);
        wait_drain();
        check("o_data_held_after_bad", 64'(o_data), 64'hE51AFF00);

        // Short lead mark, then a good frame, then a repeat code.
        drive(1'b1, 6000);
        push_now(EV_ERR, m_data);
        drive(1'b0, 2000);
        check("busy_after_short_lead", 64'(o_busy), 0);
        send_frame(32'h00FF00FF);
        send_repeat();
        wait_drain();
        check("o_data_after_repeat", 64'(o_data), 64'h00FF00FF);

        // Mark held for 15 ms after a lead space: timeout near 12 ms.
        send_lead();
        t0 = cyc;
        push(EV_ERR, m_data, t0 + 11990, t0 + 12020);
        i_ir_rxb = 1'b0;
        repeat (6000 * CPU) @(negedge clk);
        check("busy_mid_hold", 64'(o_busy), 1);
        repeat (9000 * CPU) @(negedge clk);
        drive(1'b0, 2000);
        check("busy_after_timeout", 64'(o_busy), 0);
        wait_drain();

        // Random payload with an out-of-window space at a random bit.
        p = mk_valid($urandom);
        k = int'($urandom_range(31));
        send_lead();
        send_bits(p, 0, k);
        drive(1'b1, jit(560));
        drive(1'b0, int'($urandom_range(1250, 760)));
        push_now(EV_ERR, m_data);
        drive(1'b1, jit(560));
        drive(1'b0, 2000);
        wait_drain();
        check("busy_after_bad_space", 64'(o_busy), 0);

        // Reset in the middle of bit 16 of a random frame.
        p = mk_valid($urandom);
        send_lead();
        send_bits(p, 0, 16);
        drive(1'b1, 300);
        i_ir_rxb = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("midrst_o_data",   64'(o_data), 0);
        check("midrst_o_valid",  64'(o_valid), 0);
        check("midrst_o_repeat", 64'(o_repeat), 0);
        check("midrst_o_err",    64'(o_err), 0);
        check("midrst_o_busy",   64'(o_busy), 0);
        m_data = '0;
        m_seen = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (3000) @(negedge clk);
        wait_drain();
        check("busy_after_release", 64'(o_busy), 0);

        // Reset forgets the accepted frame: a repeat is rejected again.
        send_repeat();
        wait_drain();
        check("o_data_after_reset_repeat", 64'(o_data), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ir_nec_rx.md
IR_NEC_RX -- requirements
Module: ir_nec_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter NBITS, default 32, range 8..32, meaning payload bits per frame.
REQ-003 SHALL have parameter TOL_PCT, default 20, range 5..40, meaning symmetric timing tolerance in percent.
REQ-004 SHALL have parameter CHK_EN, default 1, meaning that when NBITS==32 and CHK_EN==1, frame bits [31:24] are checked against the inverse of bits [23:16].
REQ-005 SHALL have parameter TIMEOUT_US, default 12000, meaning the maximum width of any single mark or space.
REQ-006 SHALL have port clk, input, 1, the system clock.
REQ-007 SHALL have port rst_n, input, 1: reset rst_n, asynchronous, active-low; clock clk.
REQ-008 SHALL have port i_ir_rxb, input, 1, the raw IR receiver output, active-low (mark = 0).
REQ-009 SHALL have port o_data, output, NBITS, the last valid frame payload.
REQ-010 SHALL have port o_valid, output, 1, a one-clk pulse when o_data updates.
REQ-011 SHALL have port o_repeat, output, 1, a one-clk pulse on an accepted repeat code.
REQ-012 SHALL have port o_err, output, 1, a one-clk pulse on a rejected frame.
REQ-013 SHALL have port o_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 SHALL synchronise i_ir_rxb through 2 flops on clk, invert it to obtain mark, and apply no other filtering.
REQ-015 SHALL derive a 1 us tick enable from clk using a CLK_HZ/1000000 counter; all widths are measured in ticks and all logic runs on clk with no derived clocks.
REQ-016 SHALL measure each mark/space width in a 16-bit counter that saturates at 0xFFFF and clears on every synchronised edge.
REQ-017 SHALL compute each window at elaboration as nominal*(100-TOL_PCT)/100 .. nominal*(100+TOL_PCT)/100 ticks, inclusive, using these nominals: lead mark 9000, lead space 4500, repeat space 2250, bit mark 560, zero space 560, one space 1690.
REQ-018 SHALL implement the states IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, each classified on the edge that ends the current interval.
REQ-019 SHALL make these transitions:
- IDLE -> LEAD_MARK on a mark rising edge.
- LEAD_MARK -> LEAD_SPACE when the mark is within its window; otherwise error.
- LEAD_SPACE with a lead-space width -> BIT_MARK with the bit count cleared.
- LEAD_SPACE with a repeat-space width -> STOP_MARK, see REQ-031.
- BIT_MARK -> BIT_SPACE when the width is within the bit-mark window; otherwise error.
- BIT_SPACE: a zero-space or one-space width stores the bit and increments the count; after NBITS bits the next state is STOP_MARK, otherwise BIT_MARK; any other width is an error.
- STOP_MARK: a bit-mark-window width completes the frame or repeat, then IDLE.
REQ-020 SHALL store bits LSB-first: the first received bit goes to shift[0] and the last to shift[NBITS-1].
REQ-021 SHALL, on frame completion, load o_data with shift and pulse o_valid on the next clk, provided the check of REQ-004 passes; otherwise o_err pulses and o_data is unchanged.
REQ-022 SHALL treat any interval exceeding TIMEOUT_US outside IDLE as an error, detected while the interval is still running without waiting for an edge.
REQ-023 SHALL, on any error, pulse o_err for one clk, return to IDLE, and leave o_data unchanged.
REQ-024 SHALL, if a mark edge arrives while IDLE is being entered from an error on the same clk, wait for the next rising edge; this aborted frame produces no o_valid.
REQ-025 SHALL never assert o_valid, o_repeat and o_err in the same clk.

Reset
REQ-026 SHALL, on rst_n low, asynchronously set: state IDLE; all counters 0; o_data 0; o_valid, o_repeat and o_err 0; o_busy 0; the synchroniser set to idle (no mark).
REQ-027 SHALL abort a frame in progress on reset, producing no pulse on release.
REQ-028 SHALL clear the "frame seen" flag on reset.

Configuration
REQ-029 SHALL compile repeat-code support only when macro IR_NEC_RX_REPEAT_EN is defined.
REQ-030 SHALL, when IR_NEC_RX_REPEAT_EN is undefined, treat a repeat-space width in LEAD_SPACE as an error and hold o_repeat at constant 0.
REQ-031 SHALL, when IR_NEC_RX_REPEAT_EN is defined, make a repeat code (9000 mark, 2250 space, 560 mark) pulse o_repeat only if a valid frame has been received since reset; otherwise pulse o_err; o_data is unchanged in both cases.

Verification
REQ-032 SHALL cover a valid frame with payload 0xE51AFF00 (default parameters) -> one o_valid pulse, o_data=0xE51AFF00, o_err 0.
REQ-033 SHALL cover the same frame with bit 24 flipped -> o_err pulse, o_data holds its previous value, no o_valid.
REQ-034 SHALL cover a lead mark of 6000 us -> o_err pulse, return to IDLE, and acceptance of the following valid frame.
REQ-035 SHALL cover a held mark of 15000 us after a lead space -> o_err pulse at about 12000 us and o_busy 0 afterwards.
REQ-036 SHALL cover a repeat code after a valid 0x00FF00FF frame -> with the macro, an o_repeat pulse with o_data 0x00FF00FF; without the macro, an o_err pulse.
REQ-037 SHALL cover rst_n asserted at bit 16 of a frame -> all outputs 0 immediately, and no pulse after release.
